// File: rtl/montgomery_mul_driver.sv
// montgomery_mul_driver: issues host operand pairs to a multiplier, tags them in order, buffers tagged results with credit flow control
module montgomery_mul_driver #(
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [63:0]                  cmd_a,
  input  logic [63:0]                  cmd_b,
  output logic [63:0]                  mm_a,
  output logic [63:0]                  mm_b,
  output logic                         mm_valid,
  input  logic                         mm_ready,
  input  logic [63:0]                  mm_result,
  input  logic                         mm_result_valid,
  output logic                         mm_result_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [63:0]                  rsp_data,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic [$clog2(RSP_DEPTH):0]   inflight,
  output logic                         err_unexpected
);
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int CW = AW + 1;
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] tag_q [RSP_DEPTH];
  logic [AW-1:0] tq_wr, tq_rd, rf_wr, rf_rd;
  logic [TAG_W+63:0] rsp_mem [RSP_DEPTH];
  logic [CW-1:0] rsp_count;
  logic accept, capture, unexpected, pop;
  assign cmd_ready = (!mm_valid || mm_ready) && (({1'b0, inflight} + {1'b0, rsp_count}) < (CW+1)'(RSP_DEPTH)) && !rst;
  assign accept = cmd_valid && cmd_ready;
  assign mm_result_ready = rsp_count != CW'(RSP_DEPTH);
  assign capture = mm_result_valid && mm_result_ready && inflight != '0;
  assign unexpected = mm_result_valid && inflight == '0;
  assign rsp_valid = rsp_count != '0;
  assign pop = rsp_valid && rsp_ready;
  assign {rsp_tag, rsp_data} = rsp_mem[rf_rd];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_valid <= 1'b0;
      mm_a <= '0;
      mm_b <= '0;
      tag_cnt <= '0;
      tq_wr <= '0;
      tq_rd <= '0;
      rf_wr <= '0;
      rf_rd <= '0;
      inflight <= '0;
      rsp_count <= '0;
      err_unexpected <= 1'b0;
    end else begin
      mm_valid <= accept ? 1'b1 : (mm_ready ? 1'b0 : mm_valid);
      mm_a <= accept ? cmd_a : mm_a;
      mm_b <= accept ? cmd_b : mm_b;
      tag_cnt <= tag_cnt + TAG_W'(accept);
      tq_wr <= tq_wr + AW'(accept);
      tq_rd <= tq_rd + AW'(capture);
      rf_wr <= rf_wr + AW'(capture);
      rf_rd <= rf_rd + AW'(pop);
      inflight <= inflight + CW'(accept) - CW'(capture);
      rsp_count <= rsp_count + CW'(capture) - CW'(pop);
      err_unexpected <= err_unexpected | unexpected;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) tag_q[tq_wr] <= tag_cnt;
    if (capture) rsp_mem[rf_wr] <= {tag_q[tq_rd], mm_result};
  end
endmodule

// File: tb/tb_montgomery_mul_driver.sv
// tb_montgomery_mul_driver: scoreboard bench with a behavioural multiplier and random traffic
module tb_montgomery_mul_driver;
  logic clk = 0;
  logic rst = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [63:0] cmd_a = 0, cmd_b = 0, mm_a, mm_b, mm_result = 0, rsp_data;
  logic mm_valid, mm_ready = 0, mm_result_valid = 0, mm_result_ready;
  logic rsp_valid, rsp_ready = 0, err_unexpected;
  logic [3:0] rsp_tag;
  logic [2:0] inflight;
  int total = 0, bad = 0, cyc = 0, acc = 0, cap = 0, last_due = 0, lat_fixed = 3;
  logic [3:0] tagm = 0;
  logic [67:0] exp_q [$];
  logic [67:0] e;
  logic [63:0] mq_p [$];
  int mq_due [$];
  bit inj = 0, drv_inj = 0, stall = 0, rnd = 0, rsp_rdy_set = 1;

  montgomery_mul_driver #(.RSP_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .mm_a(mm_a), .mm_b(mm_b), .mm_valid(mm_valid),
    .mm_ready(mm_ready), .mm_result(mm_result), .mm_result_valid(mm_result_valid),
    .mm_result_ready(mm_result_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .inflight(inflight), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, expv);
    end
  endfunction

  // Behavioural multiplier and host-side response sink, driven 2 time units after each edge
  always @(posedge clk) begin
    cyc++;
    #2;
    mm_ready = !rst && !stall && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
    drv_inj = inj;
    mm_result_valid = !rst && (inj || (mq_p.size() > 0 && cyc >= mq_due[0]));
    mm_result = inj ? 64'hDEAD_BEEF : (mq_p.size() > 0 ? mq_p[0] : 64'h0);
    rsp_ready = rnd ? ($urandom_range(0, 1) == 1) : rsp_rdy_set;
  end

  // Scoreboard and monitor: sample mid-cycle, then record handshakes completing at the next edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mq_p.delete();
      mq_due.delete();
      acc = 0;
      cap = 0;
      tagm = 0;
      last_due = 0;
    end else begin
      chk("cmd_ready", 64'(cmd_ready), 64'((!mm_valid || mm_ready) && exp_q.size() < 4));
      chk("inflight", 64'(inflight), 64'(acc - cap));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("spurious_rsp", 64'(rsp_tag), 64'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e[63:0]);
          chk("rsp_tag", 64'(rsp_tag), 64'(e[67:64]));
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back({tagm, cmd_a * cmd_b});
        tagm++;
        acc++;
      end
      if (mm_valid && mm_ready) begin
        last_due = (cyc + (rnd ? int'($urandom_range(1, 4)) : lat_fixed) > last_due) ?
                   cyc + (rnd ? int'($urandom_range(1, 4)) : lat_fixed) : last_due;
        mq_p.push_back(mm_a * mm_b);
        mq_due.push_back(last_due);
      end
      if (mm_result_valid && mm_result_ready && !drv_inj && mq_p.size() > 0) begin
        void'(mq_p.pop_front());
        void'(mq_due.pop_front());
        cap++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    bit ok = 0;
    cmd_valid = 1;
    cmd_a = a;
    cmd_b = b;
    do begin
      @(negedge clk);
      ok = cmd_ready;
      tick();
      n++;
    end while (!ok && n < 300);
    if (!ok) chk("send_timeout", 64'(n), 64'(0));
    cmd_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      tick();
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_accept(input int a0);
    int n = 0;
    while (acc == a0 && n < 100) begin
      tick();
      n++;
    end
    cmd_valid = 0;
    chk("accept_after_stall", 64'(acc), 64'(a0 + 1));
  endtask

  initial begin
    int a0;
    repeat (3) tick();
    chk("rst_mm_valid", 64'(mm_valid), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_err", 64'(err_unexpected), 64'(0));
    rst = 0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    tick();
    send(64'h5, 64'h7);
    chk("single_mm_valid", 64'(mm_valid), 64'(1));
    chk("single_mm_a", mm_a, 64'h5);
    chk("single_mm_b", mm_b, 64'h7);
    drain();
    tick();
    chk("single_inflight", 64'(inflight), 64'(0));
    chk("single_mm_idle", 64'(mm_valid), 64'(0));
    send(64'h3, 64'h4);
    chk("b2b_first", mm_a, 64'h3);
    send(64'h6, 64'h8);
    chk("b2b_second_valid", 64'(mm_valid), 64'(1));
    chk("b2b_second", mm_a, 64'h6);
    drain();
    rsp_rdy_set = 0;
    for (int i = 0; i < 4; i++) send({$urandom, $urandom}, {$urandom, $urandom});
    @(negedge clk);
    chk("credit_full", 64'(cmd_ready), 64'(0));
    tick();
    cmd_valid = 1;
    cmd_a = 64'h9;
    cmd_b = 64'h9;
    a0 = acc;
    repeat (10) tick();
    chk("credit_stall", 64'(acc), 64'(a0));
    rsp_rdy_set = 1;
    tick();
    rsp_rdy_set = 0;
    wait_accept(a0);
    rsp_rdy_set = 1;
    drain();
    stall = 1;
    send(64'hB, 64'hD);
    cmd_valid = 1;
    cmd_a = 64'h2;
    cmd_b = 64'h2;
    a0 = acc;
    repeat (5) begin
      @(negedge clk);
      chk("bp_mm_valid", 64'(mm_valid), 64'(1));
      chk("bp_mm_a", mm_a, 64'hB);
      chk("bp_mm_b", mm_b, 64'hD);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
      tick();
    end
    chk("bp_no_accept", 64'(acc), 64'(a0));
    stall = 0;
    wait_accept(a0);
    drain();
    inj = 1;
    tick();
    inj = 0;
    repeat (3) tick();
    chk("unexp_err", 64'(err_unexpected), 64'(1));
    chk("unexp_no_rsp", 64'(rsp_valid), 64'(0));
    chk("unexp_inflight", 64'(inflight), 64'(0));
    rnd = 1;
    for (int i = 0; i < 60; i++) begin
      send({$urandom, $urandom}, {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd = 0;
    drain();
    lat_fixed = 20;
    send(64'h11, 64'h22);
    send(64'h33, 64'h44);
    tick();
    chk("mid_inflight", 64'(inflight), 64'(2));
    rst = 1;
    #1;
    chk("mid_rst_mm_valid", 64'(mm_valid), 64'(0));
    chk("mid_rst_mm_a", mm_a, 64'h0);
    chk("mid_rst_mm_b", mm_b, 64'h0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_inflight", 64'(inflight), 64'(0));
    chk("mid_rst_err", 64'(err_unexpected), 64'(0));
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(0));
    tick();
    tick();
    rst = 0;
    lat_fixed = 3;
    tick();
    for (int i = 0; i < 17; i++) send(64'(i + 1), 64'h100);
    drain();
    chk("wrap_tagm", 64'(tagm), 64'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end
endmodule

// File: doc/montgomery_mul_driver.md
MONTGOMERY_MUL_DRIVER -- requirements
Module: montgomery_mul_driver

Interface
REQ-001 Parameter: RSP_DEPTH, 4, result-buffer depth and in-flight credit limit; power of two, 2..16.
REQ-002 Parameter: TAG_W, 4, width of the transaction tag.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  host offers an operand pair.
REQ-007 cmd_ready  out  1  block accepts the operand pair this cycle.
REQ-008 cmd_a / cmd_b  in  64 each  host operands.
REQ-009 mm_a / mm_b  out  64 each  operands to the multiplier (its a/b).
REQ-010 mm_valid  out  1  drives multiplier valid_in.
REQ-011 mm_ready  in  1  from multiplier ready_out.
REQ-012 mm_result  in  64  from multiplier result.
REQ-013 mm_result_valid  in  1  from multiplier valid_out.
REQ-014 mm_result_ready  out  1  drives multiplier ready_in.
REQ-015 rsp_valid  out  1  response available.
REQ-016 rsp_ready  in  1  host consumes the response.
REQ-017 rsp_data  out  64  product returned to the host.
REQ-018 rsp_tag  out  TAG_W  tag of the command that produced rsp_data.
REQ-019 inflight  out  $clog2(RSP_DEPTH)+1  accepted commands whose result has not yet been captured.
REQ-020 err_unexpected  out  1  sticky flag: a result arrived with inflight==0.

Function
REQ-021 Credit rule: cmd_ready SHALL be 1 iff (!mm_valid || mm_ready) && (inflight + rsp_count) < RSP_DEPTH && !rst.
REQ-022 A command is accepted when cmd_valid && cmd_ready at a rising edge; on the next cycle mm_a/mm_b SHALL hold the operands and mm_valid SHALL be 1.
REQ-023 While mm_valid && !mm_ready, mm_a, mm_b and mm_valid SHALL stay stable; mm_valid SHALL drop after the handshake edge unless a new command is accepted on the same edge, giving one issue per cycle.
REQ-024 Tags SHALL be assigned from a counter starting at 0, +1 per accepted command, wrapping from 2^TAG_W-1 to 0.
REQ-025 Each assigned tag SHALL be pushed into an in-order tag queue of depth RSP_DEPTH; results return in issue order.
REQ-026 inflight SHALL increment on command accept, decrement on result capture, and stay unchanged when both occur on the same edge.
REQ-027 mm_result_ready SHALL be 1 whenever the response FIFO is not full; the credit rule guarantees it is never full while inflight>0.
REQ-028 A result is captured on mm_result_valid && mm_result_ready with inflight>0: {tag-queue head, mm_result} is pushed to the response FIFO and the tag queue pops.
REQ-029 With mm_result_valid && inflight==0, the result SHALL be discarded, err_unexpected SHALL set, and no counter SHALL change.
REQ-030 Response FIFO: depth RSP_DEPTH. rsp_valid = !empty, and rsp_data/rsp_tag show the head entry. Pop on rsp_valid && rsp_ready. Push and pop on the same edge SHALL both happen, including when the FIFO is full or empty-with-push.
REQ-031 Latency: a result captured at edge M SHALL appear on rsp_valid after edge M (1 cycle). The driver adds 1 cycle on the issue side.
REQ-032 rsp_data/rsp_tag SHALL stay stable while rsp_valid && !rsp_ready.

Reset
REQ-033 On rst, immediately: mm_valid=0, mm_a=mm_b=0, rsp_valid=0, inflight=0, tag counter=0, both queues empty, err_unexpected=0, cmd_ready=0.
REQ-034 Reset mid-operation SHALL discard all in-flight and buffered transactions. Results arriving after reset release SHALL be treated as unexpected (REQ-029).
REQ-035 One cycle after rst deasserts, cmd_ready SHALL be 1 (credits=RSP_DEPTH).

Verification
REQ-036 Single op: cmd a=0x5 b=0x7, model multiplier returns 0x23 after 3 cycles -> mm_valid one cycle after accept; rsp_data=0x23, rsp_tag=0, inflight back to 0.
REQ-037 Back-to-back: (0x3,0x4) then (0x6,0x8) on consecutive cycles with mm_ready=1 -> two consecutive mm_valid beats; responses 0xC tag 0, then 0x30 tag 1, in order.
REQ-038 Credit exhaustion: rsp_ready=0, issue 4 commands with RSP_DEPTH=4 -> cmd_ready=0 after the 4th; the 5th stalls; after one rsp_ready pulse, the 5th is accepted.
REQ-039 Issue backpressure: mm_ready=0 for 5 cycles after accept -> mm_a/mm_b/mm_valid constant, cmd_ready=0; mm_ready=1 -> handshake, then the next command is accepted.
REQ-040 Tag wrap: 17 commands -> the 16th response has tag 0xF, the 17th has tag 0x0.
REQ-041 Faults: inject mm_result_valid with inflight==0 -> err_unexpected=1 and no response; assert rst with 2 in flight -> all outputs at reset values, err cleared.
